// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and helpers for the systolic feeder.
// Optional feature macro used by the top: SYSTOLIC_FEEDER_PERF_EN.
package systolic_pkg;

  // Feeder sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  // Zero-injection cycles needed after the last slice so the far corner
  // PE sees the final operands: N-1 cycles of skew plus N-1 of array travel plus 1.
  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

  // Flush counter width; holds values up to 2N-2.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// skew_line: DEPTH-stage shift register, cleared to zero by reset.
// Gives one feeder lane its skew delay (lane k uses DEPTH = k+1).
module skew_line #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] sr;

  // Shift one stage per cycle; stage 0 captures the injected value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: transmit side of an NxN systolic PE array.
// Takes one k-slice (A column + B row) per handshake, skews lane i by i+1
// cycles, pulses the array's sync reset before streaming, zero-flushes the
// grid after the last slice and pulses done.
// Define SYSTOLIC_FEEDER_PERF_EN to add perf_cycles / perf_bubbles counters.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [N*DATA_WIDTH-1:0] in_a,
  input  logic [N*DATA_WIDTH-1:0] in_b,
  output logic [N*DATA_WIDTH-1:0] x_lanes,
  output logic [N*DATA_WIDTH-1:0] w_lanes,
  output logic                  arr_rst_n,
  output logic                  busy,
  output logic                  done
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_bubbles
`endif
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(flush_cycles(N) - 1);

  state_e                         state;
  logic [CW-1:0]                  fcnt;
  logic                           accept;
  logic [N-1:0][DATA_WIDTH-1:0]   inj_a;
  logic [N-1:0][DATA_WIDTH-1:0]   inj_b;
  logic [N-1:0][DATA_WIDTH-1:0]   x_q;
  logic [N-1:0][DATA_WIDTH-1:0]   w_q;

  assign in_ready  = (state == STREAM);
  assign accept    = in_valid & in_ready;
  assign busy      = (state != IDLE);
  // PE reset is synchronous, so one low cycle in CLEAR clears the whole grid
  assign arr_rst_n = (state != CLEAR);

  // Only an accepted slice enters the skew line; every other cycle injects a
  // zero bubble, which multiplies out to nothing at every PE.
  assign inj_a = accept ? in_a : '0;
  assign inj_b = accept ? in_b : '0;

  // Sequencer: IDLE -> CLEAR -> STREAM -> FLUSH -> IDLE, done on FLUSH exit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      fcnt  <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == FLUSH) && (fcnt == '0);
      case (state)
        IDLE:   if (start) state <= CLEAR;
        CLEAR:  state <= STREAM;
        STREAM: if (accept && in_last) begin
                  state <= FLUSH;
                  fcnt  <= FLUSH_LOAD;
                end
        FLUSH:  if (fcnt == '0) state <= IDLE;
                else            fcnt  <= fcnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // One skew line per x lane and per w lane; lane g delayed g+1 cycles
  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(g + 1)) u_x (
      .clk (clk),
      .rst (rst),
      .din (inj_a[g]),
      .dout(x_q[g])
    );
    skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(g + 1)) u_w (
      .clk (clk),
      .rst (rst),
      .din (inj_b[g]),
      .dout(w_q[g])
    );
  end

  assign x_lanes = x_q;
  assign w_lanes = w_q;

`ifdef SYSTOLIC_FEEDER_PERF_EN
  // Saturating activity counters, cleared at the start of each operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else if (state == CLEAR) begin
      perf_cycles  <= '0;
      perf_bubbles <= '0;
    end else begin
      if ((state == STREAM || state == FLUSH) && perf_cycles != '1)
        perf_cycles <= perf_cycles + 32'd1;
      if (state == STREAM && !accept && perf_bubbles != '1)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench: systolic_feeder driving a behavioural 4x4 PE grid.
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [N*DW-1:0] in_a = '0;
  logic [N*DW-1:0] in_b = '0;
  logic in_ready, arr_rst_n, busy, done;
  logic [N*DW-1:0] x_lanes, w_lanes;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [31:0] perf_cycles, perf_bubbles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_a(in_a), .in_b(in_b),
    .x_lanes(x_lanes), .w_lanes(w_lanes), .arr_rst_n(arr_rst_n),
    .busy(busy), .done(done)
`ifdef SYSTOLIC_FEEDER_PERF_EN
    , .perf_cycles(perf_cycles), .perf_bubbles(perf_bubbles)
`endif
  );

  // Behavioural output-stationary PE grid: x flows right, w flows down
  logic [31:0] xr [N][N];
  logic [31:0] wr [N][N];
  logic [31:0] acc[N][N];
  always @(posedge clk) begin : grid
    logic [31:0] xi, wi;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        xi = (j == 0) ? x_lanes[i*DW +: DW] : xr[i][j-1];
        wi = (i == 0) ? w_lanes[j*DW +: DW] : wr[i-1][j];
        if (!arr_rst_n) begin
          xr[i][j] <= '0; wr[i][j] <= '0; acc[i][j] <= '0;
        end else begin
          xr[i][j] <= xi; wr[i][j] <= wi; acc[i][j] <= acc[i][j] + xi * wi;
        end
      end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pk(input int v0, input int v1, input int v2, input int v3);
    logic [31:0] a0, a1, a2, a3;
    a0 = v0; a1 = v1; a2 = v2; a3 = v3;
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] onehot(input int k);
    logic [127:0] r;
    r = '0;
    r[k*32] = 1'b1;
    return r;
  endfunction

  // Waits for done with a cycle budget; counts arr_rst_n low cycles on the way
  task automatic wait_done(output int n, output int lows);
    n = 0; lows = 0;
    while (done !== 1'b1 && n < 40) begin
      tick(); n++;
      if (arr_rst_n !== 1'b1) lows++;
    end
  endtask

  task automatic check_identity(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_y%0d%0d", tag, i, j), acc[i][j], (i == j) ? 1 : 0);
  endtask

  int n, lows, k, dones;
  int vp[7] = '{1, 0, 1, 0, 0, 1, 1};

  initial begin
    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_arr", arr_rst_n, 1);
    chk("rst_x", x_lanes, 0);
    chk("rst_w", w_lanes, 0);
    rst = 1'b1;
    tick();

    // 1: identity, back-to-back slices
    start = 1; tick(); start = 0;
    chk("t1_clear_arr", arr_rst_n, 0);
    chk("t1_clear_busy", busy, 1);
    tick();
    chk("t1_stream_ready", in_ready, 1);
    chk("t1_stream_arr", arr_rst_n, 1);
    for (int s = 0; s < 4; s++) begin
      in_valid = 1; in_a = onehot(s); in_b = onehot(s); in_last = (s == 3);
      tick();
    end
    in_valid = 0; in_last = 0;
    chk("t1_flush_ready", in_ready, 0);
    wait_done(n, lows);
    chk("t1_done", done, 1);
    chk("t1_done_lat", n, 7);
    chk("t1_done_busy", busy, 0);
    check_identity("t1");
    tick();
    chk("t1_done_pulse", done, 0);

    // 2: identity with three bubbles
    start = 1; tick(); start = 0; tick();
    k = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid = vp[c][0];
      in_a = onehot(k); in_b = onehot(k);
      in_last = (vp[c] == 1 && k == 3);
      tick();
      if (vp[c] == 1) k++;
    end
    in_valid = 0; in_last = 0;
    wait_done(n, lows);
    chk("t2_done", done, 1);
    check_identity("t2");
`ifdef SYSTOLIC_FEEDER_PERF_EN
    chk("t2_bubbles", perf_bubbles, 3);
    chk("t2_cycles", perf_cycles, 14);
`endif
    tick();

    // 3: single outer-product slice, skew timing on lane 3
    start = 1; tick(); start = 0; tick();
    in_valid = 1; in_a = pk(1, 2, 3, 4); in_b = pk(5, 6, 7, 8); in_last = 1;
    tick();
    in_valid = 0; in_last = 0;
    chk("t3_x0_lat1", x_lanes[31:0], 1);
    tick(); tick();
    chk("t3_x3_early", x_lanes[127:96], 0);
    tick();
    chk("t3_x3_lat4", x_lanes[127:96], 4);
    chk("t3_w3_lat4", w_lanes[127:96], 8);
    tick();
    chk("t3_x3_gone", x_lanes[127:96], 0);
    wait_done(n, lows);
    chk("t3_done", done, 1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("t3_y%0d%0d", i, j), acc[i][j], (i + 1) * (j + 5));

    // 4: start held through an op and into the done cycle
    tick();
    start = 1; tick();
    chk("t4_clear", arr_rst_n, 0);
    tick();
    chk("t4_one_low", arr_rst_n, 1);
    in_valid = 1; in_a = pk(1, 1, 1, 1); in_b = pk(2, 2, 2, 2); in_last = 1;
    tick();
    in_valid = 0; in_last = 0;
    wait_done(n, lows);
    chk("t4_done", done, 1);
    chk("t4_no_restart_lat", n, 7);
    chk("t4_no_midop_clear", lows, 0);
    chk("t4_y", acc[2][1], 2);
    tick();
    chk("t4_restart_clear", arr_rst_n, 0);
    chk("t4_restart_busy", busy, 1);
    start = 0;
    tick();
    chk("t4_restart_stream", in_ready, 1);
    chk("t4_restart_arr", arr_rst_n, 1);
    in_valid = 1; in_a = '0; in_b = '0; in_last = 1;
    tick();
    in_valid = 0; in_last = 0;
    wait_done(n, lows);
    chk("t4b_done", done, 1);
    tick();

    // 5: reset during FLUSH
    start = 1; tick(); start = 0; tick();
    in_valid = 1; in_a = pk(1, 2, 3, 4); in_b = pk(5, 6, 7, 8); in_last = 1;
    tick();
    in_valid = 0; in_last = 0;
    tick();
    chk("t5_pre_x1", x_lanes[63:32], 2);
    chk("t5_pre_busy", busy, 1);
    rst = 0; #1;
    chk("t5_busy", busy, 0);
    chk("t5_x", x_lanes, 0);
    chk("t5_w", w_lanes, 0);
    chk("t5_arr", arr_rst_n, 1);
    chk("t5_ready", in_ready, 0);
    #2; rst = 1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("t5_no_done", dones, 0);

    // 6: in_valid high outside STREAM
    in_valid = 1; in_a = pk(9, 9, 9, 9); in_b = pk(9, 9, 9, 9);
    tick(); tick(); tick();
    chk("t6_idle_ready", in_ready, 0);
    chk("t6_idle_x", x_lanes, 0);
    chk("t6_idle_w", w_lanes, 0);
    start = 1; tick(); start = 0;
    chk("t6_clear_ready", in_ready, 0);
    in_a = pk(1, 2, 3, 4); in_b = pk(5, 6, 7, 8); in_last = 1;
    tick();
    chk("t6_clear_x", x_lanes, 0);
    tick();
    in_a = pk(9, 9, 9, 9); in_b = pk(9, 9, 9, 9); in_last = 0;
    chk("t6_flush_ready", in_ready, 0);
    wait_done(n, lows);
    in_valid = 0;
    chk("t6_done", done, 1);
    chk("t6_x_drained", x_lanes, 0);
    chk("t6_w_drained", w_lanes, 0);
    chk("t6_y33", acc[3][3], 32);
    chk("t6_y00", acc[0][0], 5);
    chk("t6_y21", acc[2][1], 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
